// File: rtl/cpu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pipe_pkg: shared definitions for the five-stage CPU pipeline registers.
//   - state_e           : occupancy state of a skid pipeline stage (value = count)
//   - CTRL_* indices    : bit positions inside the control vector
//   - KILL_MASK_DEF     : control bits dropped on a killed capture (RegWrite)
//   - *_CTRL_W/*_DATA_W : per-stage vector widths
// -----------------------------------------------------------------------------
package cpu_pipe_pkg;

   // Encoding equals the number of held entries, so occupancy is the state.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_e;

   // Control-vector bit layout
   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMTOREG = 1;
   localparam int CTRL_BRANCH   = 2;
   localparam int CTRL_MEMREAD  = 3;
   localparam int CTRL_MEMWRITE = 4;
   localparam int CTRL_REGDST   = 5;
   localparam int CTRL_ALUSRCA  = 6;
   localparam int CTRL_ALUSRCB  = 7;
   localparam int CTRL_ALUOP_LO = 8;   // 4-bit ALU op in [11:8]
   localparam int CTRL_ALUOP_W  = 4;

   localparam int PIPE_CTRL_W = 16;
   localparam int PIPE_DATA_W = 192;

   localparam logic [PIPE_CTRL_W-1:0] KILL_MASK_DEF = PIPE_CTRL_W'(1) << CTRL_REGWRITE;

   // Per-stage widths
   localparam int IFID_DATA_W  = 64;    // pc, pc+4/instr
   localparam int IDEX_DATA_W  = 192;   // pc, pc+4, busA, busB, imm, rt/rd
   localparam int EXMEM_DATA_W = 128;
   localparam int MEMWB_DATA_W = 96;

endpackage

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot: one {valid, ctrl, data} register of a pipeline stage.
//   clk, reset        : clock, async active-low reset
//   load_i            : capture ctrl_d_i/data_d_i and mark valid
//   clear_i           : drop the entry (valid=0, ctrl=0); wins over load_i.
//                       Data is kept so a bubble does not toggle the datapath.
//   valid_o/ctrl_o/data_o : held entry
// -----------------------------------------------------------------------------
module pipe_slot #(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 192
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [CTRL_W-1:0] ctrl_d_i,
   input  logic [DATA_W-1:0] data_d_i,
   output logic              valid_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o
);

   logic              valid_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         data_q  <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         ctrl_q  <= ctrl_d_i;
         data_q  <= data_d_i;
      end
   end

   assign valid_o = valid_q;
   assign ctrl_o  = ctrl_q;
   assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid: generic pipeline-stage register with a 2-entry skid buffer.
//   clk, reset            : clock, async active-low reset
//   in_valid/in_ready     : upstream handshake (in_ready is registered state only)
//   in_ctrl/in_data       : incoming control/data vectors
//   in_kill               : clear KILL_MASK bits of in_ctrl on capture
//   flush                 : synchronous squash of held entries and current input
//   out_valid/out_ready   : downstream handshake
//   out_ctrl/out_data     : main entry (ctrl forced to 0 while invalid)
//   occupancy             : entries held, 0..2
// -----------------------------------------------------------------------------
module pipe_stage_skid
   import cpu_pipe_pkg::*;
#(
   parameter int                CTRL_W    = PIPE_CTRL_W,
   parameter int                DATA_W    = PIPE_DATA_W,
   parameter logic [CTRL_W-1:0] KILL_MASK = CTRL_W'(KILL_MASK_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_kill,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   state_e state_q, state_d;

   logic              accept, fire;
   logic [CTRL_W-1:0] cap_ctrl;

   logic              main_load, main_clr, main_from_skid;
   logic              skid_load, skid_clr;
   logic              main_vld, skid_vld;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
   logic [DATA_W-1:0] main_data, skid_data, main_data_d;

   // Ready comes from state only: no combinational path from out_ready.
   assign in_ready  = (state_q != FULL);
   assign accept    = in_valid & in_ready;
   assign fire      = main_vld & out_ready;
   assign cap_ctrl  = in_kill ? (in_ctrl & ~KILL_MASK) : in_ctrl;
   assign occupancy = state_q;

   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_clr       = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clr       = 1'b0;
      if (flush) begin
         // Squash everything; a same-cycle fire already completed downstream.
         state_d  = EMPTY;
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         unique case (state_q)
            EMPTY: if (accept) begin
               main_load = 1'b1;
               state_d   = BUSY;
            end
            BUSY: begin
               if (accept && fire) begin
                  main_load = 1'b1;
               end else if (accept) begin
                  skid_load = 1'b1;
                  state_d   = FULL;
               end else if (fire) begin
                  main_clr = 1'b1;
                  state_d  = EMPTY;
               end
            end
            FULL: if (fire) begin
               main_load      = 1'b1;
               main_from_skid = 1'b1;
               skid_clr       = 1'b1;
               state_d        = BUSY;
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Skid is always older than the input, so it refills main first.
   assign main_ctrl_d = main_from_skid ? skid_ctrl : cap_ctrl;
   assign main_data_d = main_from_skid ? skid_data : in_data;

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk      (clk),
      .reset    (reset),
      .load_i   (main_load),
      .clear_i  (main_clr),
      .ctrl_d_i (main_ctrl_d),
      .data_d_i (main_data_d),
      .valid_o  (main_vld),
      .ctrl_o   (main_ctrl),
      .data_o   (main_data)
   );

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk      (clk),
      .reset    (reset),
      .load_i   (skid_load),
      .clear_i  (skid_clr),
      .ctrl_d_i (cap_ctrl),
      .data_d_i (in_data),
      .valid_o  (skid_vld),
      .ctrl_o   (skid_ctrl),
      .data_o   (skid_data)
   );

   assign out_valid = main_vld;
   assign out_ctrl  = main_vld ? main_ctrl : '0;
   assign out_data  = main_data;

   // skid_vld is implied by state FULL; kept for readability in waves.
   logic unused_skid_vld;
   assign unused_skid_vld = skid_vld;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

   localparam int CW = 16;
   localparam int DW = 192;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid, in_ready, in_kill, flush;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [DW-1:0] in_data, out_data;
   logic          out_valid, out_ready;
   logic [1:0]    occupancy;

   int n_checks = 0;
   int n_pass   = 0;

   pipe_stage_skid dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .in_kill(in_kill), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mk(input int n);
      mk = {6{32'(n)}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 0; in_kill = 0; flush = 0; in_ctrl = '0; in_data = '0;
   endtask

   task automatic test_reset();
      reset = 0; out_ready = 0; idle();
      repeat (3) tick();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++; if (out_ctrl !== '0) $display("FAIL rst_ctrl: got %h want 0", out_ctrl); else n_pass++;
      n_checks++; if (out_data !== '0) $display("FAIL rst_data: got %h want 0", out_data); else n_pass++;
      n_checks++; if (occupancy !== 2'd0) $display("FAIL rst_occ: got %0d want 0", occupancy); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", in_ready); else n_pass++;
      reset = 1;
      tick();
   endtask

   task automatic test_stream();
      logic [DW-1:0] d [3];
      d[0] = mk(32'hA); d[1] = mk(32'hB); d[2] = mk(32'hC);
      out_ready = 1; in_valid = 1; in_ctrl = 16'h0013;
      for (int i = 0; i < 3; i++) begin
         in_data = d[i];
         tick();
         n_checks++; if (out_valid !== 1'b1 || out_data !== d[i] || out_ctrl !== 16'h0013 || occupancy !== 2'd1)
            $display("FAIL stream_%0d: got v=%b c=%h d=%h o=%0d want v=1 c=0013 d=%h o=1", i, out_valid, out_ctrl, out_data[31:0], occupancy, d[i][31:0]);
         else n_pass++;
      end
      idle();
      tick();
      n_checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0 || out_data !== d[2])
         $display("FAIL stream_drain: got v=%b c=%h o=%0d d=%h want v=0 c=0 o=0 d=%h", out_valid, out_ctrl, occupancy, out_data[31:0], d[2][31:0]);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      out_ready = 0; in_valid = 1; in_ctrl = 16'h0013;
      in_data = mk(32'h1A); tick();
      n_checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== mk(32'h1A))
         $display("FAIL bp_one: got o=%0d r=%b d=%h want o=1 r=1 d=1a", occupancy, in_ready, out_data[31:0]);
      else n_pass++;
      in_data = mk(32'h1B); tick();
      n_checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== mk(32'h1A) || out_valid !== 1'b1)
         $display("FAIL bp_full: got o=%0d r=%b v=%b d=%h want o=2 r=0 v=1 d=1a", occupancy, in_ready, out_valid, out_data[31:0]);
      else n_pass++;
      in_data = mk(32'h1C); tick();
      n_checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== mk(32'h1A))
         $display("FAIL bp_stall: got o=%0d r=%b d=%h want o=2 r=0 d=1a", occupancy, in_ready, out_data[31:0]);
      else n_pass++;
      out_ready = 1; tick();
      n_checks++; if (out_data !== mk(32'h1B) || occupancy !== 2'd1 || in_ready !== 1'b1)
         $display("FAIL bp_rel_b: got d=%h o=%0d r=%b want d=1b o=1 r=1", out_data[31:0], occupancy, in_ready);
      else n_pass++;
      tick();
      n_checks++; if (out_data !== mk(32'h1C) || out_valid !== 1'b1 || occupancy !== 2'd1)
         $display("FAIL bp_rel_c: got d=%h v=%b o=%0d want d=1c v=1 o=1", out_data[31:0], out_valid, occupancy);
      else n_pass++;
      idle(); tick();
      n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
         $display("FAIL bp_empty: got v=%b o=%0d want v=0 o=0", out_valid, occupancy);
      else n_pass++;
   endtask

   task automatic test_kill();
      out_ready = 1; in_valid = 1; in_ctrl = 16'h00FF; in_kill = 1; in_data = mk(32'hD0);
      tick();
      n_checks++; if (out_ctrl !== 16'h00FE || out_data !== mk(32'hD0))
         $display("FAIL kill_on: got c=%h d=%h want c=00fe d=d0", out_ctrl, out_data[31:0]);
      else n_pass++;
      in_kill = 0; in_data = mk(32'hE0);
      tick();
      n_checks++; if (out_ctrl !== 16'h00FF || out_data !== mk(32'hE0))
         $display("FAIL kill_off: got c=%h d=%h want c=00ff d=e0", out_ctrl, out_data[31:0]);
      else n_pass++;
      idle(); tick();
   endtask

   task automatic test_flush();
      // Flush while FULL, input valid the same cycle
      out_ready = 0; in_valid = 1; in_ctrl = 16'h0013;
      in_data = mk(32'h2A); tick();
      in_data = mk(32'h2B); tick();
      in_data = mk(32'h2C); flush = 1; tick();
      n_checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0 || in_ready !== 1'b1)
         $display("FAIL flush_full: got v=%b c=%h o=%0d r=%b want v=0 c=0 o=0 r=1", out_valid, out_ctrl, occupancy, in_ready);
      else n_pass++;
      flush = 0; in_valid = 0; out_ready = 1; tick(); tick();
      n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
         $display("FAIL flush_no_ghost: got v=%b o=%0d want v=0 o=0", out_valid, occupancy);
      else n_pass++;
      // Flush in BUSY with a real accept: input is dropped
      in_valid = 1; in_data = mk(32'h2D); tick();
      in_data = mk(32'h2E); flush = 1; tick();
      n_checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0)
         $display("FAIL flush_busy: got v=%b c=%h o=%0d want v=0 c=0 o=0", out_valid, out_ctrl, occupancy);
      else n_pass++;
      idle(); tick();
      n_checks++; if (out_valid !== 1'b0)
         $display("FAIL flush_drop: got v=%b d=%h want v=0", out_valid, out_data[31:0]);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      out_ready = 0; in_valid = 1; in_ctrl = 16'h0013;
      in_data = mk(32'h3A); tick();
      in_data = mk(32'h3B); tick();
      idle();
      #3 reset = 0;
      #1;
      n_checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || occupancy !== 2'd0 || in_ready !== 1'b1)
         $display("FAIL async_rst: got v=%b c=%h d=%h o=%0d r=%b want all 0 r=1", out_valid, out_ctrl, out_data[31:0], occupancy, in_ready);
      else n_pass++;
      #1 reset = 1;
      tick();
      out_ready = 1; in_valid = 1; in_ctrl = 16'h0013; in_data = mk(32'h3F);
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_data !== mk(32'h3F) || occupancy !== 2'd1)
         $display("FAIL async_post: got v=%b d=%h o=%0d want v=1 d=3f o=1", out_valid, out_data[31:0], occupancy);
      else n_pass++;
      idle(); tick();
   endtask

   task automatic test_random();
      logic [CW+DW-1:0] q[$];
      logic [CW+DW-1:0] exp;
      logic [CW-1:0]    ec;
      logic             hold;
      int               seq, errs, cnt;
      hold = 0; seq = 32'h1000; errs = 0; cnt = 0;
      for (int i = 0; i < 10000 + 8; i++) begin
         if (!hold) begin
            if (i < 10000) begin
               in_valid = ($urandom_range(0, 3) != 0);
               in_ctrl  = 16'($urandom);
               in_kill  = $urandom_range(0, 1) == 1;
               in_data  = mk(seq);
            end else in_valid = 0;
         end
         out_ready = (i >= 10000) ? 1'b1 : ($urandom_range(0, 2) != 0);
         if (in_ready !== (occupancy != 2'd2)) errs++;
         if (!out_valid && out_ctrl !== '0) errs++;
         if (out_valid && out_ready) begin
            cnt++;
            if (q.size() == 0) errs++;
            else begin
               exp = q.pop_front();
               if ({out_ctrl, out_data} !== exp) begin
                  errs++;
                  if (errs < 5) $display("FAIL rand_order: got c=%h d=%h want c=%h d=%h", out_ctrl, out_data[31:0], exp[DW+:CW], exp[31:0]);
               end
            end
         end
         if (in_valid && in_ready) begin
            ec = in_kill ? (in_ctrl & ~16'h0001) : in_ctrl;
            q.push_back({ec, in_data});
            seq++;
         end
         hold = in_valid && !in_ready;
         tick();
      end
      n_checks++; if (errs != 0) $display("FAIL rand_errors: got %0d want 0", errs); else n_pass++;
      n_checks++; if (q.size() != 0 || out_valid !== 1'b0) $display("FAIL rand_drain: got left=%0d v=%b want 0 0", q.size(), out_valid); else n_pass++;
      n_checks++; if (cnt < 1000) $display("FAIL rand_traffic: got %0d want >=1000", cnt); else n_pass++;
      idle();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_kill();
      test_flush();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
